// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive path and frame_gen.
//   parity_t   : programmed parity handling for the parity slot
//   rx_state_t : receiver frame-tracking states
//   DATA_W / FRAME_W : default byte width and full frame width (start+data+parity+stop)
package uart_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FRAME_W = DATA_W + 3;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NOCHK = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  // Only even and odd actually compare the parity slot; the others just consume it.
  function automatic logic parity_checked(parity_t t);
    return (t == PAR_EVEN) || (t == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous rx line.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (flops reset to 1 = line idle)
//   d_i      : asynchronous input
//   q_o      : synchronised output
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Reset to 1 so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: oversampled UART frame receiver.
// Deserialises start, DATA_W data bits (LSB first), a parity slot and a stop bit,
// then presents the byte with a one-clk data_valid strobe and parity/framing flags.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   sample_tick  : one-clk strobe at OVS x baud rate
//   rx_in        : asynchronous serial line, idles high
//   parity_type  : 00 none, 01 even, 10 odd, 11 slot present but unchecked
//   data_out     : last received byte, held until the next frame completes
//   data_valid   : one-clk pulse when data_out and the flags update
//   parity_err   : parity mismatch of the last delivered frame
//   frame_err    : stop bit of the last delivered frame sampled low
//   busy         : high from start detection until the receiver is idle again
// OVS must be even and >= 4; DATA_W must be >= 2.
module uart_frame_rx #(
  parameter int unsigned OVS    = 16,
  parameter int unsigned DATA_W = uart_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              rx_in,
  input  logic [1:0]        parity_type,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  import uart_pkg::*;

  localparam int unsigned TICK_W = $clog2(OVS);
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVS / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  logic rx_s;

  rx_state_t         state_q;
  logic [TICK_W-1:0] tick_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  parity_t           par_type_q;
  logic              par_bit_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic              busy_q;
  logic              exp_par_c;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_in),
    .q_o (rx_s)
  );

  // Expected parity slot value for the captured byte.
  assign exp_par_c = (par_type_q == PAR_ODD) ? ~(^shift_q) : (^shift_q);

  // Frame tracking FSM; all counters advance only on sample ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_type_q   <= PAR_NONE;
      par_bit_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (sample_tick) begin
        case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q    <= START;
              tick_q     <= '0;
              busy_q     <= 1'b1;
              par_type_q <= parity_t'(parity_type);
            end
          end
          START: begin
            // Re-check the line at mid start bit to reject glitches.
            if (tick_q == TICK_HALF) begin
              if (rx_s) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= DATA;
                tick_q  <= '0;
                bit_q   <= '0;
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
          DATA: begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              // Shift in from the top so the first bit ends up in bit 0.
              shift_q <= {rx_s, shift_q[DATA_W-1:1]};
              if (bit_q == BIT_LAST) begin
                state_q <= PARITY;
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
          PARITY: begin
            if (tick_q == TICK_LAST) begin
              tick_q    <= '0;
              par_bit_q <= rx_s;
              state_q   <= STOP;
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
          STOP: begin
            if (tick_q == TICK_LAST) begin
              tick_q       <= '0;
              data_out_q   <= shift_q;
              data_valid_q <= 1'b1;
              parity_err_q <= parity_checked(par_type_q) && (par_bit_q != exp_par_c);
              frame_err_q  <= ~rx_s;
              if (rx_s) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                // Line still low: wait for it to recover before hunting for a new start.
                state_q <= BREAK_WAIT;
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
          BREAK_WAIT: begin
            if (rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: scoreboard bench for uart_frame_rx (OVS=16, tick every clk).
// Frames are serialised bit by bit; each sent frame pushes its expected
// byte/flags computed from the frame contents; a monitor pops on data_valid.
module tb_uart_frame_rx;

  localparam int unsigned OVS = 16;
  localparam int unsigned DW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_tick;
  logic          rx_in;
  logic [1:0]    parity_type;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_sent   = 0;
  int   n_rx     = 0;

  uart_frame_rx #(.OVS(OVS), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .rx_in       (rx_in),
    .parity_type (parity_type),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: count ones over data + parity slot; even type wants an even total.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [1:0] t,
                                 input logic p, input logic s);
    exp_t e;
    int   ones;
    ones   = $countones(d) + ((p === 1'b1) ? 1 : 0);
    e.d    = d;
    e.ferr = (s == 1'b0);
    case (t)
      2'b01:   e.perr = (ones % 2) != 0;
      2'b10:   e.perr = (ones % 2) == 0;
      default: e.perr = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic good_par(input logic [DW-1:0] d, input logic [1:0] t);
    int ones;
    ones = $countones(d);
    return (t == 2'b10) ? ((ones % 2) == 0) : ((ones % 2) != 0);
  endfunction

  task automatic drive_bit(input logic b);
    repeat (OVS) begin
      @(negedge clk);
      rx_in = b;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  // Serialise one frame; parity_type is scrambled after the start slot to
  // confirm it is only sampled at start detection.
  task automatic send_frame(input logic [DW-1:0] d, input logic [1:0] t,
                            input logic p, input logic s);
    parity_type = t;
    exp_q.push_back(model(d, t, p, s));
    n_sent++;
    drive_bit(1'b0);
    parity_type = 2'($urandom);
    for (int i = 0; i < int'(DW); i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic wait_not_busy(input string name, input int bound);
    for (int k = 0; k < bound && busy; k++) @(negedge clk);
    check(name, 32'(busy), 32'(0));
  endtask

  // Monitor: every valid must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      n_rx++;
      check("valid_has_expect", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("data_out",   32'(data_out),   32'(mon_e.d));
        check("parity_err", 32'(parity_err), 32'(mon_e.perr));
        check("frame_err",  32'(frame_err),  32'(mon_e.ferr));
        check("busy_at_valid", 32'(busy),    32'(mon_e.ferr));
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    logic [1:0]    t;
    logic          p;
    logic          s;

    rst         = 1'b1;
    rx_in       = 1'b1;
    sample_tick = 1'b1;
    parity_type = 2'b00;
    #2;
    check("rst_data_out",   32'(data_out),   32'(0));
    check("rst_data_valid", 32'(data_valid), 32'(0));
    check("rst_parity_err", 32'(parity_err), 32'(0));
    check("rst_frame_err",  32'(frame_err),  32'(0));
    check("rst_busy",       32'(busy),       32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(6);

    // Directed frames.
    send_frame(8'hA5, 2'b01, 1'b0, 1'b1);
    idle(4);
    check("hold_data_out", 32'(data_out), 32'(8'hA5));
    send_frame(8'h3C, 2'b10, 1'b0, 1'b1);
    send_frame(8'h3C, 2'b10, 1'b1, 1'b1);
    send_frame(8'h81, 2'b11, 1'b0, 1'b1);
    send_frame(8'h81, 2'b00, 1'b0, 1'b1);
    idle(8);

    // Stop bit low followed by a held-low line.
    send_frame(8'h55, 2'b01, 1'b0, 1'b0);
    repeat (64) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    check("break_busy_held", 32'(busy), 32'(1));
    @(negedge clk);
    rx_in = 1'b1;
    wait_not_busy("break_release", 8);
    idle(20);

    // Short glitch must be rejected at mid start.
    repeat (4) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    @(negedge clk);
    rx_in = 1'b1;
    wait_not_busy("glitch_busy_clear", int'(OVS / 2 + 3));
    idle(20);

    // Back-to-back frames.
    send_frame(8'h12, 2'b01, good_par(8'h12, 2'b01), 1'b1);
    send_frame(8'h34, 2'b01, good_par(8'h34, 2'b01), 1'b1);
    idle(8);

    // Reset in the middle of the data slots.
    parity_type = 2'b01;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] == 1'b0 ? 1'b0 : 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_data_out",   32'(data_out),   32'(0));
    check("midrst_data_valid", 32'(data_valid), 32'(0));
    check("midrst_parity_err", 32'(parity_err), 32'(0));
    check("midrst_frame_err",  32'(frame_err),  32'(0));
    check("midrst_busy",       32'(busy),       32'(0));
    @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(6);
    send_frame(8'h0F, 2'b01, good_par(8'h0F, 2'b01), 1'b1);
    idle(6);

    // Randomised frames, including bad parity and occasional framing errors.
    for (int n = 0; n < 40; n++) begin
      d = DW'($urandom);
      t = 2'($urandom_range(0, 3));
      p = ($urandom_range(0, 3) == 0) ? ~good_par(d, t) : good_par(d, t);
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, t, p, s);
      if (!s) idle(int'($urandom_range(20, 30)));
      else    idle(int'($urandom_range(0, 12)));
    end

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    check("frames_seen",   32'(n_rx),         32'(n_sent));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Receive-side counterpart of frame_gen. It takes the serial line and deserialises one 11-bit frame: start, 8 data bits LSB first, parity slot, stop. It then checks the parity slot against the programmed parity type and checks the stop bit. Each frame is delivered as one data byte with a one-cycle valid strobe and error flags. It sits between the pad-side rx line and the receive FIFO or host logic, and is driven by a shared oversample tick generator.

Parameters:
OVS, 16, oversample ticks per bit period; must be even and ≥4.
DATA_W, 8, data bits per frame; the frame is DATA_W+3 bits.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
sample_tick  input  1  one-clk strobe at OVS × baud rate
rx_in  input  1  asynchronous serial line; idles high
parity_type  input  2  00 none, 01 even, 10 odd, 11 no check (slot present, ignored)
data_out  output  DATA_W  received byte; held until the next frame completes
data_valid  output  1  one-clk pulse when data_out/flags update
parity_err  output  1  parity mismatch for the frame just delivered; valid with data_valid, held after
frame_err  output  1  stop bit sampled 0; valid with data_valid, held after
busy  output  1  high from start detection until return to IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; data_out=0; data_valid=0; parity_err=0; frame_err=0; busy=0; counters cleared; synchroniser flops set to 1.
- rx_in passes through a 2-flop synchroniser (rx_s). All decisions use rx_s. Counters advance only on clk edges where sample_tick=1.
- Frame slots are always present (DATA_W+3 bits). For types 00 and 11 the parity slot is consumed but not checked, and parity_err is forced to 0.
- parity_type is latched at start detection; changes mid-frame have no effect.
- IDLE: on a tick with rx_s=0, go to START, tick_cnt=0, busy=1.
- START: on the tick where tick_cnt reaches OVS/2-1 (mid start bit), re-sample rx_s:
  - rx_s=1: false start; go to IDLE, busy=0, no outputs change.
  - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
- DATA: sample rx_s at tick_cnt=OVS-1 and shift it into bit position bit_cnt (LSB first). After DATA_W samples, go to PARITY.
- PARITY: sample at tick_cnt=OVS-1 and store p.
  - Expected value: even (01) = XOR of data bits; odd (10) = inverted XOR of data bits.
  - Then go to STOP.
- STOP: sample at tick_cnt=OVS-1 (mid stop bit). In the following clk:
  - data_out <= shift register; data_valid=1 for exactly one clk.
  - parity_err <= (type 01/10) and (p ≠ expected).
  - frame_err <= ~stop_sample.
  - Next state: IDLE if the stop sample was 1, else BREAK_WAIT.
- BREAK_WAIT: busy=1. Stay until a tick with rx_s=1, then go to IDLE (busy=0). This prevents a held-low line from producing repeated frames.
- Back-to-back frames: the next start edge can be detected from IDLE on the first tick after return, i.e. half a bit after mid-stop. No gap is required.
- Latency: data_valid rises 1 clk after the mid-stop-bit tick.
- sample_tick held high every clk is legal (OVS clocks per bit).
- Reset mid-frame: immediate abort to IDLE. The partial frame is discarded and no data_valid is produced.

Decomposition:
- uart_pkg holds:
  - parity_t enum: PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10, PAR_NOCHK=2'b11; shared with frame_gen.
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - localparams FRAME_W=11 and DATA_W=8.
- One sub-module, uart_rx_sync: 2-flop synchroniser with async-reset-to-1.

Test Plan (OVS=16, sample_tick every clk, bit period=16 clks):
- Type 01, byte 0xA5. Line: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1 -> data_valid pulse; data_out=0xA5, parity_err=0, frame_err=0; busy falls after mid-stop.
- Type 10, byte 0x3C (expected parity 1), parity slot driven 0 -> data_out=0x3C, parity_err=1, frame_err=0. Then send 0x3C with parity 1 -> parity_err=0.
- Type 11, byte 0x81, parity slot 0 -> parity_err=0. Same frame with type 00 -> parity_err=0.
- Type 01, byte 0x55, stop bit 0, line held low 64 clks then high:
  - one data_valid with frame_err=1, data_out=0x55.
  - no further data_valid while low; busy stays 1 until the line is high.
- Glitch: rx_in low for 4 clks then high -> no data_valid, busy returns to 0 within OVS/2+3 clks. Two back-to-back frames 0x12, 0x34 -> two pulses, correct values.
- Assert rst during the DATA slot of 0xF0 -> all outputs 0 immediately. The next clean frame 0x0F is received correctly.
